seq_divider_ctrl: RTL and testbench

//  Multi-cycle unsigned restoring divider. An FSM sequences one shared
//  (N+1)-bit Subtractor instance over N iterations to produce quotient and

---
 rtl/alu_pkg.sv | 19 +
 rtl/Subtractor.sv | 19 +
 rtl/seq_divider_ctrl.sv | 117 +++++++++++
 tb/tb_seq_divider_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM states and counter sizing.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_N = 4;

    // The counter must be able to hold N without wrapping.
    function automatic int div_cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

    localparam int DIV_CNT_W = div_cnt_w(DIV_N);

endpackage

// File: rtl/Subtractor.sv
// W-bit unsigned subtractor a - b with ALU-style flags; purely combinational.
// negative is the borrow out (a < b unsigned), zero flags a == b.
module Subtractor #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         negative,
    output logic         zero
);

    logic borrow;

    assign {borrow, diff} = {1'b0, a} - {1'b0, b};
    assign negative       = borrow;
    assign zero           = (diff == '0);

endmodule

// File: rtl/seq_divider_ctrl.sv
// Restoring unsigned divider: one trial subtraction per cycle, done N+1 cycles after start
// (1 cycle for divide-by-zero); start is ignored while busy, with no queueing.
module seq_divider_ctrl
    import alu_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int            CW       = div_cnt_w(N);
    localparam int            RW       = N + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    div_state_t    state, state_nx;
    logic [RW-1:0] r, r_nx, t, diff, r_step;
    logic [N-1:0]  q, q_nx, d, d_nx, q_step;
    logic [N-1:0]  quo_nx, rem_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          negative, zero, ge;
    logic          busy_nx, done_nx, dbz_nx;

    // Shift {R,Q} left by one; R's top bit is always zero because R < D.
    assign t = RW'({r, q[N-1]});

    Subtractor #(.W(RW)) u_sub (
        .a        (t),
        .b        ({1'b0, d}),
        .diff     (diff),
        .negative (negative),
        .zero     (zero)
    );

    assign ge     = !negative || zero;
    assign r_step = ge ? diff : t;
    assign q_step = {q[N-2:0], ge};

    always_comb begin
        state_nx = state;
        r_nx     = r;
        q_nx     = q;
        d_nx     = d;
        cnt_nx   = cnt;
        quo_nx   = quotient;
        rem_nx   = remainder;
        dbz_nx   = div_by_zero;
        case (state)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        state_nx = CALC;
                        d_nx     = divisor;
                        q_nx     = dividend;
                        r_nx     = '0;
                        cnt_nx   = '0;
                        dbz_nx   = 1'b0;
                    end else begin
                        state_nx = DONE;
                        quo_nx   = '1;
                        rem_nx   = dividend;
                        dbz_nx   = 1'b1;
                    end
                end
            end
            CALC: begin
                r_nx   = r_step;
                q_nx   = q_step;
                cnt_nx = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nx = DONE;
                    quo_nx   = q_step;
                    rem_nx   = r_step[N-1:0];
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx != IDLE);
        done_nx = (state_nx == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_nx;
            r           <= r_nx;
            q           <= q_nx;
            d           <= d_nx;
            cnt         <= cnt_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            quotient    <= quo_nx;
            remainder   <= rem_nx;
            div_by_zero <= dbz_nx;
        end
    end

endmodule

// File: tb/tb_seq_divider_ctrl.sv
// Directed and sweep bench for seq_divider_ctrl with N = 4.
module tb_seq_divider_ctrl;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_divider_ctrl #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start from IDLE, wait for done (bounded), return results and
    // the number of edges from the accepting edge to the done cycle (inclusive).
    task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b,
                           output logic [N-1:0] qo, output logic [N-1:0] ro,
                           output logic dz, output int lat);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        qo = quotient;
        ro = remainder;
        dz = div_by_zero;
        tick();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000", {busy, done, div_by_zero});
        end
        checks++;
        if ({quotient, remainder} !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got %h expected 00", {quotient, remainder});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [N-1:0] qo, ro;
        logic         dz;
        int           lat;
        run_div(4'd13, 4'd3, qo, ro, dz, lat);
        checks++;
        if (lat !== N + 1) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected %0d", lat, N + 1);
        end
        checks++;
        if (qo !== 4'd4) begin
            errors++;
            $display("FAIL basic_quotient: got %0d expected 4", qo);
        end
        checks++;
        if (ro !== 4'd1) begin
            errors++;
            $display("FAIL basic_remainder: got %0d expected 1", ro);
        end
        checks++;
        if (dz !== 1'b0) begin
            errors++;
            $display("FAIL basic_dbz: got %b expected 0", dz);
        end
        checks++;
        if ({busy, done, quotient, remainder} !== {1'b0, 1'b0, 4'd4, 4'd1}) begin
            errors++;
            $display("FAIL basic_hold: got busy=%b done=%b q=%0d r=%0d expected 0 0 4 1",
                     busy, done, quotient, remainder);
        end
    endtask

    task automatic test_edge_cases();
        logic [N-1:0] ta[3] = '{4'd15, 4'd2, 4'd6};
        logic [N-1:0] tb[3] = '{4'd1, 4'd9, 4'd6};
        logic [N-1:0] eq[3] = '{4'd15, 4'd0, 4'd1};
        logic [N-1:0] er[3] = '{4'd0, 4'd2, 4'd0};
        logic [N-1:0] qo, ro;
        logic         dz;
        int           lat;
        for (int i = 0; i < 3; i++) begin
            run_div(ta[i], tb[i], qo, ro, dz, lat);
            checks++;
            if (qo !== eq[i] || ro !== er[i] || dz !== 1'b0) begin
                errors++;
                $display("FAIL edge_%0d_%0d: got q=%0d r=%0d dbz=%b expected q=%0d r=%0d dbz=0",
                         ta[i], tb[i], qo, ro, dz, eq[i], er[i]);
            end
            checks++;
            if (lat !== N + 1) begin
                errors++;
                $display("FAIL edge_latency_%0d: got %0d expected %0d", i, lat, N + 1);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [N-1:0] qo, ro;
        logic         dz;
        int           lat;
        run_div(4'd7, 4'd0, qo, ro, dz, lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL dbz_latency: got %0d expected 1", lat);
        end
        checks++;
        if (dz !== 1'b1 || qo !== 4'd15 || ro !== 4'd7) begin
            errors++;
            $display("FAIL dbz_result: got dbz=%b q=%0d r=%0d expected 1 15 7", dz, qo, ro);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL dbz_no_calc: got busy=%b expected 0", busy);
        end
        // Accepted start clears the flag at once; results stay until the new done.
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (div_by_zero !== 1'b0 || quotient !== 4'd15 || remainder !== 4'd7) begin
            errors++;
            $display("FAIL dbz_clear_on_start: got dbz=%b q=%0d r=%0d expected 0 15 7",
                     div_by_zero, quotient, remainder);
        end
        for (int n = 0; n < 6; n++) tick();
    endtask

    task automatic test_busy_ignore();
        int done_cnt = 0;
        int done_at  = 0;
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            checks++;
            if (busy !== (n <= N + 1)) begin
                errors++;
                $display("FAIL busy_cycle_%0d: got %b expected %b", n, busy, (n <= N + 1));
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_at = n;
            end
            if (n == 2) begin
                dividend = 4'd9;
                divisor  = 4'd2;
                start    = 1'b1;
            end
            if (n == 3) start = 1'b0;
            tick();
        end
        checks++;
        if (done_cnt !== 1 || done_at !== N + 1) begin
            errors++;
            $display("FAIL busy_done_pulse: got count=%0d at=%0d expected count=1 at=%0d",
                     done_cnt, done_at, N + 1);
        end
        checks++;
        if (quotient !== 4'd4 || remainder !== 4'd1) begin
            errors++;
            $display("FAIL busy_operands: got q=%0d r=%0d expected 4 1", quotient, remainder);
        end
    endtask

    task automatic test_reset_abort();
        logic [N-1:0] qo, ro;
        logic         dz;
        int           lat;
        int           seen = 0;
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 11'd0) begin
            errors++;
            $display("FAIL abort_immediate: got busy=%b done=%b dbz=%b q=%0d r=%0d expected all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            if (done === 1'b1 || busy === 1'b1) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d busy/done cycles expected 0", seen);
        end
        run_div(4'd9, 4'd2, qo, ro, dz, lat);
        checks++;
        if (qo !== 4'd4 || ro !== 4'd1 || lat !== N + 1) begin
            errors++;
            $display("FAIL abort_recover: got q=%0d r=%0d lat=%0d expected 4 1 %0d",
                     qo, ro, lat, N + 1);
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] ea, eb, eq, er;
        int           n;
        int           want_gap;
        dividend = 4'd0;
        divisor  = 4'd0;
        start    = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ea = i[7:4];
            eb = i[3:0];
            n  = 0;
            do begin
                tick();
                n++;
            end while (done !== 1'b1 && n < 20);
            eq       = (eb == 0) ? 4'hF : ea / eb;
            er       = (eb == 0) ? ea : ea % eb;
            want_gap = (eb == 0) ? 2 : N + 2;
            checks++;
            if (done !== 1'b1) begin
                errors++;
                $display("FAIL sweep_timeout_%0d_%0d: no done within %0d cycles", ea, eb, n);
            end
            checks++;
            if (quotient !== eq || remainder !== er || div_by_zero !== (eb == 0)) begin
                errors++;
                $display("FAIL sweep_%0d_%0d: got q=%0d r=%0d dbz=%b expected q=%0d r=%0d dbz=%b",
                         ea, eb, quotient, remainder, div_by_zero, eq, er, (eb == 0));
            end
            if (i > 0) begin
                checks++;
                if (n !== want_gap) begin
                    errors++;
                    $display("FAIL sweep_gap_%0d_%0d: got %0d expected %0d", ea, eb, n, want_gap);
                end
            end
            if (i < 255) begin
                dividend = 4'((i + 1) >> 4);
                divisor  = 4'((i + 1) & 15);
            end else begin
                start = 1'b0;
            end
        end
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL sweep_drain: got busy=%b expected 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edge_cases();
        test_div_zero();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
